// File: rtl/graphic_pkg.sv
// Shared types and colour constants for the layered pixel renderer.
package graphic_pkg;

    localparam int CX_W = 11;
    localparam int CY_W = 10;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef struct packed {
        logic            en;
        logic [CX_W-1:0] x;
        logic [CY_W-1:0] y;
    } sprite_t;

    localparam rgb_t PALETTE [8] = '{
        rgb_t'(12'hFF0), rgb_t'(12'h0FF), rgb_t'(12'hF0F), rgb_t'(12'hF80),
        rgb_t'(12'h00F), rgb_t'(12'hFFF), rgb_t'(12'h80F), rgb_t'(12'h088)
    };

    localparam rgb_t BLACK_RGB      = rgb_t'(12'h000);
    localparam rgb_t SAFE_RGB       = rgb_t'(12'h030);
    localparam rgb_t UNSAFE_RGB     = rgb_t'(12'hF00);
    localparam rgb_t UNSAFE_DIM_RGB = rgb_t'(12'h400);
    localparam rgb_t GRID_RGB       = rgb_t'(12'h888);

    // Palette wraps every 8 slots.
    function automatic rgb_t palette_rgb(input int idx);
        return PALETTE[3'(idx)];
    endfunction

endpackage

// File: rtl/graphic_layers_sprite_hit.sv
// Combinational hit test for one square sprite slot; right/bottom edges clip.
module sprite_hit
    import graphic_pkg::*;
#(
    parameter int SPRITE_SIZE = 16
)(
    input  logic            en_i,
    input  logic [CX_W-1:0] x_i,
    input  logic [CY_W-1:0] y_i,
    input  logic [CX_W-1:0] h_i,
    input  logic [CY_W-1:0] v_i,
    output logic            hit_o
);
    localparam logic [CX_W:0] SZ_X = (CX_W+1)'(SPRITE_SIZE);
    localparam logic [CY_W:0] SZ_Y = (CY_W+1)'(SPRITE_SIZE);

    logic [CX_W:0] x_end;
    logic [CY_W:0] y_end;
    logic          in_x;
    logic          in_y;

    // One extra bit on the far edge so sprites near the border never wrap to 0.
    always_comb begin
        x_end = {1'b0, x_i} + SZ_X;
        y_end = {1'b0, y_i} + SZ_Y;
        in_x  = (h_i >= x_i) && ({1'b0, h_i} < x_end);
        in_y  = (v_i >= y_i) && ({1'b0, v_i} < y_end);
        hit_o = en_i && in_x && in_y;
    end

endmodule

// File: rtl/graphic_layers.sv
// Layered pixel renderer: background zone with blink, prioritised sprites and,
// when GRAPHIC_LAYERS_GRID_EN is defined, a debug grid. Two-clock latency.
module graphic_layers
    import graphic_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 800,
    parameter int SCREEN_HEIGHT = 600,
    parameter int NUM_SPRITES   = 4,
    parameter int SPRITE_SIZE   = 16,
    parameter int BLINK_FRAMES  = 30,
    localparam int XW = $clog2(SCREEN_WIDTH),
    localparam int YW = $clog2(SCREEN_HEIGHT),
    localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
)(
    input  logic          clk,
    input  logic          rst_n,
    output logic [XW-1:0] o_screen_x,
    output logic [YW-1:0] o_screen_y,
    input  logic          i_is_safe,
    input  logic          i_spr_valid,
    output logic          o_spr_ready,
    input  logic [IW-1:0] i_spr_idx,
    input  logic [XW-1:0] i_spr_x,
    input  logic [YW-1:0] i_spr_y,
    input  logic          i_spr_en,
    output logic          o_frame_start,
    output logic [3:0]    red,
    output logic [3:0]    green,
    output logic [3:0]    blue,
    input  logic          disp_enbl,
    input  logic [10:0]   h_coord,
    input  logic [9:0]    v_coord
);
    localparam int BW = $clog2(BLINK_FRAMES) + 1;

    logic                   commit;
    logic                   spr_we;
    sprite_t                wr_spr;
    sprite_t                shadow_q [NUM_SPRITES];
    sprite_t                active_q [NUM_SPRITES];
    logic                   frame_start_q;
    logic [BW-1:0]          blink_cnt_q, blink_cnt_d;
    logic                   blink_ph_q, blink_ph_d;
    logic [NUM_SPRITES-1:0] hit_d;
    logic [NUM_SPRITES-1:0] hit_s1_q;
    logic                   vld_s1_q;
    logic                   safe_s1_q;
    logic                   spr_any;
    rgb_t                   spr_rgb;
    rgb_t                   pix_d, pix_q;

    // Shadow slots commit at the first pixel of vertical blank.
    assign commit      = (h_coord == '0) && (v_coord == CY_W'(SCREEN_HEIGHT));
    assign o_spr_ready = ~commit;
    assign spr_we      = i_spr_valid & o_spr_ready;
    assign wr_spr      = '{en: i_spr_en, x: CX_W'(i_spr_x), y: CY_W'(i_spr_y)};

    always_comb begin
        if (h_coord > 11'(SCREEN_WIDTH - 1)) o_screen_x = XW'(SCREEN_WIDTH - 1);
        else                                 o_screen_x = XW'(h_coord);
        if (v_coord > 10'(SCREEN_HEIGHT - 1)) o_screen_y = YW'(SCREEN_HEIGHT - 1);
        else                                  o_screen_y = YW'(v_coord);
    end

    // Out-of-range indices match no slot, so those writes are simply dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (spr_we && (i_spr_idx == IW'(i))) shadow_q[i] <= wr_spr;
                if (commit)                          active_q[i] <= shadow_q[i];
            end
        end
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (commit) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start_q <= 1'b0;
            blink_cnt_q   <= '0;
            blink_ph_q    <= 1'b0;
        end else begin
            frame_start_q <= commit;
            blink_cnt_q   <= blink_cnt_d;
            blink_ph_q    <= blink_ph_d;
        end
    end

    assign o_frame_start = frame_start_q;

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
        sprite_hit #(.SPRITE_SIZE(SPRITE_SIZE)) u_hit (
            .en_i  (active_q[g].en),
            .x_i   (active_q[g].x),
            .y_i   (active_q[g].y),
            .h_i   (h_coord),
            .v_i   (v_coord),
            .hit_o (hit_d[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_s1_q  <= 1'b0;
            safe_s1_q <= 1'b0;
            hit_s1_q  <= '0;
        end else begin
            vld_s1_q  <= disp_enbl;
            safe_s1_q <= i_is_safe;
            hit_s1_q  <= hit_d;
        end
    end

`ifdef GRAPHIC_LAYERS_GRID_EN
    logic grid_d;
    logic grid_s1_q;

    assign grid_d = ((h_coord[4:0] == 5'd0) || (v_coord[4:0] == 5'd0)) &&
                    (h_coord < 11'(SCREEN_WIDTH)) && (v_coord < 10'(SCREEN_HEIGHT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) grid_s1_q <= 1'b0;
        else        grid_s1_q <= grid_d;
    end
`endif

    // Scan from the top index down so the lowest-index hit wins.
    always_comb begin
        spr_any = 1'b0;
        spr_rgb = BLACK_RGB;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_s1_q[i]) begin
                spr_any = 1'b1;
                spr_rgb = palette_rgb(i);
            end
        end
    end

    always_comb begin
        pix_d = BLACK_RGB;
        if (!vld_s1_q)       pix_d = BLACK_RGB;
`ifdef GRAPHIC_LAYERS_GRID_EN
        else if (grid_s1_q)  pix_d = GRID_RGB;
`endif
        else if (spr_any)    pix_d = spr_rgb;
        else if (safe_s1_q)  pix_d = SAFE_RGB;
        else if (blink_ph_q) pix_d = UNSAFE_DIM_RGB;
        else                 pix_d = UNSAFE_RGB;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pix_q <= BLACK_RGB;
        else        pix_q <= pix_d;
    end

    assign red   = pix_q.r;
    assign green = pix_q.g;
    assign blue  = pix_q.b;

endmodule

// File: tb/tb_graphic_layers.sv
// Self-checking bench for graphic_layers: directed frame scenarios plus random
// pixels/writes against a frame-level reference model.
module tb_graphic_layers;
    import graphic_pkg::*;

    localparam int W  = 800;
    localparam int H  = 600;
    localparam int N  = 4;
    localparam int SZ = 16;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  o_screen_x;
    logic [9:0]  o_screen_y;
    logic        i_is_safe = 1'b0;
    logic        i_spr_valid = 1'b0;
    logic        o_spr_ready;
    logic [1:0]  i_spr_idx = '0;
    logic [9:0]  i_spr_x = '0;
    logic [9:0]  i_spr_y = '0;
    logic        i_spr_en = 1'b0;
    logic        o_frame_start;
    logic [3:0]  red, green, blue;
    logic        disp_enbl = 1'b0;
    logic [10:0] h_coord = '0;
    logic [9:0]  v_coord = '0;

    always #5 clk = ~clk;

    graphic_layers #(
        .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .NUM_SPRITES(N),
        .SPRITE_SIZE(SZ), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .o_screen_x(o_screen_x), .o_screen_y(o_screen_y),
        .i_is_safe(i_is_safe),
        .i_spr_valid(i_spr_valid), .o_spr_ready(o_spr_ready),
        .i_spr_idx(i_spr_idx), .i_spr_x(i_spr_x), .i_spr_y(i_spr_y), .i_spr_en(i_spr_en),
        .o_frame_start(o_frame_start),
        .red(red), .green(green), .blue(blue),
        .disp_enbl(disp_enbl), .h_coord(h_coord), .v_coord(v_coord)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: shadow/active slots and the number of commits seen.
    int sh_en [N], sh_x [N], sh_y [N];
    int act_en[N], act_x[N], act_y[N];
    int commits;
    int exp_q[$];

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_pix(input int h, input int v, input int de, input int safe);
        if (de == 0) return 0;
`ifdef GRAPHIC_LAYERS_GRID_EN
        if (h < W && v < H && (h % 32 == 0 || v % 32 == 0)) return 'h888;
`endif
        for (int i = 0; i < N; i++)
            if (act_en[i] != 0 && h >= act_x[i] && h < act_x[i] + SZ &&
                v >= act_y[i] && v < act_y[i] + SZ)
                return int'(PALETTE[i % 8]);
        if (safe != 0) return 'h030;
        return (((commits / BF) % 2) != 0) ? 'h400 : 'hF00;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            sh_en[i] = 0; sh_x[i] = 0; sh_y[i] = 0;
            act_en[i] = 0; act_x[i] = 0; act_y[i] = 0;
        end
        commits = 0;
        exp_q.delete();
        exp_q.push_back(0);
    endtask

    // One pixel clock, entered and left at the falling edge.
    task automatic step(input int h, input int v, input int de, input int safe,
                        input int wv = 0, input int widx = 0, input int wx = 0,
                        input int wy = 0, input int wen = 0);
        int cm;
        h_coord = 11'(h); v_coord = 10'(v);
        disp_enbl = 1'(de); i_is_safe = 1'(safe);
        i_spr_valid = 1'(wv); i_spr_idx = 2'(widx);
        i_spr_x = 10'(wx); i_spr_y = 10'(wy); i_spr_en = 1'(wen);
        cm = (h == 0 && v == H) ? 1 : 0;
        #1;
        chk("ready", int'(o_spr_ready), 1 - cm);
        chk("screen_x", int'(o_screen_x), (h > W - 1) ? W - 1 : h);
        chk("screen_y", int'(o_screen_y), (v > H - 1) ? H - 1 : v);
        exp_q.push_back(model_pix(h, v, de, safe));
        @(posedge clk);
        if (wv != 0 && cm == 0 && widx < N) begin
            sh_en[widx] = wen; sh_x[widx] = wx; sh_y[widx] = wy;
        end
        if (cm != 0) begin
            for (int i = 0; i < N; i++) begin
                act_en[i] = sh_en[i]; act_x[i] = sh_x[i]; act_y[i] = sh_y[i];
            end
            commits++;
        end
        @(negedge clk);
        chk("frame_start", int'(o_frame_start), cm);
        if (exp_q.size() >= 2) chk("rgb", int'({red, green, blue}), exp_q.pop_front());
    endtask

    task automatic commit_frame();
        step(0, H, 0, 1);
    endtask

    initial begin
        model_clear();
        #1;
        chk("rst_rgb", int'({red, green, blue}), 0);
        chk("rst_ready", int'(o_spr_ready), 1);
        chk("rst_fs", int'(o_frame_start), 0);
        disp_enbl = 1'b1; i_is_safe = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rgb_held", int'({red, green, blue}), 0);
        rst_n = 1'b1;

        // Safe background appears two clocks after the coordinates.
        step(10, 10, 1, 1); step(11, 10, 1, 1); step(12, 10, 1, 1);

        // Mid-frame write stays invisible until the commit.
        step(50, 20, 1, 1, 1, 0, 100, 100, 1);
        step(100, 100, 1, 1);
        commit_frame();
        step(100, 100, 1, 1); step(115, 115, 1, 1); step(116, 100, 1, 1);
        step(100, 116, 1, 1); step(99, 100, 1, 0);

        // Overlap priority, then disable the winner.
        step(10, 30, 1, 1, 1, 0, 190, 190, 1);
        step(11, 30, 1, 1, 1, 1, 195, 195, 1);
        commit_frame();
        step(200, 200, 1, 1);
        step(12, 30, 1, 1, 1, 0, 190, 190, 0);
        commit_frame();
        step(200, 200, 1, 1); step(195, 195, 1, 1); step(194, 195, 1, 1);

        // Right-edge clipping without wrap.
        step(13, 30, 1, 1, 1, 2, 790, 300, 1);
        commit_frame();
        for (int h = 786; h < W; h++) step(h, 300, 1, 1);
        for (int h = 0; h <= 5; h++) step(h, 300, 1, 1);

        // Unsafe blink across successive frames.
        for (int k = 0; k < 6; k++) begin
            step(400, 50, 1, 0);
            commit_frame();
        end
        step(400, 50, 1, 0); step(401, 50, 1, 0);

        // Write presented in the commit cycle stalls one clock.
        step(0, H, 0, 1, 1, 3, 300, 400, 1);
        step(1, H, 0, 1, 1, 3, 300, 400, 1);
        step(300, 400, 1, 1);
        commit_frame();
        step(300, 400, 1, 1); step(305, 405, 0, 1); step(306, 405, 1, 1);

        // Asynchronous reset mid-frame.
        step(300, 400, 1, 1); step(301, 400, 1, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_rgb", int'({red, green, blue}), 0);
        chk("midrst_fs", int'(o_frame_start), 0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        step(300, 400, 1, 1); step(301, 400, 1, 0); step(302, 400, 1, 1);

        // Randomised pixels, writes and commits.
        for (int n = 0; n < 2000; n++) begin
            int r, h, v, s, de, wv, widx, wx, wy, wen, safe;
            r    = int'($urandom_range(0, 99));
            wv   = ($urandom_range(0, 4) == 0) ? 1 : 0;
            widx = int'($urandom_range(0, N - 1));
            wx   = int'($urandom_range(0, W - 1));
            wy   = int'($urandom_range(0, H - 1));
            wen  = ($urandom_range(0, 3) != 0) ? 1 : 0;
            safe = int'($urandom_range(0, 1));
            if (r < 4) begin
                step(0, H, 0, safe, wv, widx, wx, wy, wen);
            end else begin
                s = int'($urandom_range(0, N - 1));
                if ($urandom_range(0, 1) != 0) begin
                    h = act_x[s] + int'($urandom_range(0, 21)) - 3;
                    v = act_y[s] + int'($urandom_range(0, 21)) - 3;
                    if (h < 0) h = 0;
                    if (v < 0) v = 0;
                end else begin
                    h = int'($urandom_range(0, 1055));
                    v = int'($urandom_range(0, 639));
                end
                de = ($urandom_range(0, 9) != 0 && !(h == 0 && v == H)) ? 1 : 0;
                step(h, v, de, safe, wv, widx, wx, wy, wen);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/graphic_layers.md
Name: graphic_layers

Overview:
- Parametrised pixel renderer for the VGA path. Successor to the single-ball renderer.
- Composes three layers into 4-bit-per-channel RGB for each active pixel:
  - background safe/unsafe zone, with unsafe blink;
  - N square sprites with fixed priority;
  - an optional debug grid.
- Sits between the VGA timing generator (h_coord/v_coord/disp_enbl) and the DAC pins.
- Sprite positions are written by game logic through a valid/ready port and take effect only at vertical blank, so there is no tearing.

Parameters:
- SCREEN_WIDTH, 800, active pixels per line
- SCREEN_HEIGHT, 600, active lines per frame
- NUM_SPRITES, 4, number of sprite slots (1..16)
- SPRITE_SIZE, 16, sprite edge length in pixels
- BLINK_FRAMES, 30, frames per half-period of the unsafe blink

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- o_screen_x  out  $clog2(SCREEN_WIDTH)  query x to map logic
- o_screen_y  out  $clog2(SCREEN_HEIGHT)  query y to map logic
- i_is_safe  in  1  map response for the current query, combinational from the map
- i_spr_valid  in  1  sprite write request
- o_spr_ready  out  1  write accepted this cycle
- i_spr_idx  in  $clog2(NUM_SPRITES) (min 1)  slot index
- i_spr_x  in  $clog2(SCREEN_WIDTH)  sprite left edge
- i_spr_y  in  $clog2(SCREEN_HEIGHT)  sprite top edge
- i_spr_en  in  1  slot visible
- o_frame_start  out  1  one-cycle pulse when shadow registers commit
- red, green, blue  out  4 each  colour output
- disp_enbl  in  1  display enable
- h_coord  in  11  horizontal pixel coordinate
- v_coord  in  10  vertical pixel coordinate

Behaviour:
- Reset values: all colours 0, o_frame_start 0, o_spr_ready 1, blink counter 0, blink phase 0. Every shadow and active sprite slot has en=0, x=0, y=0.
- Query outputs:
  - o_screen_x = min(h_coord, SCREEN_WIDTH-1) and o_screen_y = min(v_coord, SCREEN_HEIGHT-1), both combinational.
  - i_is_safe is sampled in stage 1 alongside the coordinates.
- Pipeline latency is exactly 2 clocks from h_coord/v_coord/disp_enbl to RGB.
  - Stage 1 registers the coordinates, disp_enbl, is_safe and the per-sprite hit vector.
  - Stage 2 registers the colour mux.
- Hit test: a sprite hits when en=1 and sx <= h < sx+SPRITE_SIZE and sy <= v < sy+SPRITE_SIZE.
  - Sums are computed one bit wider than the coordinate, so sprites near the right or bottom edge clip and never wrap.
- Priority, highest first: grid (when compiled in), lowest-index hit sprite, background.
- Sprite colour is a per-index constant from the package palette, indexed modulo 8.
- Background: safe pixel = green 4'h3; unsafe pixel = red 4'hF in blink phase 0 and 4'h4 in phase 1.
- Output gating: when disp_enbl delayed by 2 is 0, RGB = 0 regardless of layers.
- Write port:
  - o_spr_ready is deasserted only during the commit cycle.
  - A write is accepted on i_spr_valid && o_spr_ready and updates the shadow slot i_spr_idx.
  - Writes with i_spr_idx >= NUM_SPRITES are accepted and dropped.
- Commit:
  - Fires on the cycle where h_coord==0 and v_coord==SCREEN_HEIGHT.
  - All shadow slots are copied to the active slots and o_frame_start pulses for one cycle in the same cycle.
  - A write presented in the commit cycle stalls (ready=0) and lands one cycle later, so it takes effect the next frame.
- Blink:
  - The counter increments on each commit.
  - At BLINK_FRAMES-1 the counter wraps to 0 and the phase toggles.
  - While the stage-1 is_safe of every pixel in a frame is 1, the phase is irrelevant; the counter still runs.
- An asynchronous reset mid-frame clears everything immediately. Output stays black until disp_enbl is re-observed through the 2-stage pipe.

Optional Feature:
- Macro: GRAPHIC_LAYERS_GRID_EN.
- Defined: pixels with h[4:0]==0 or v[4:0]==0 in the active area render grey (4'h8 on all channels), above sprites. The grid check is registered in stage 1, so latency is unchanged.
- Undefined: grid logic is absent and priority is sprite over background.

Decomposition:
- Package graphic_pkg holds:
  - the rgb_t struct (three 4-bit fields);
  - the sprite_t struct (en, x, y);
  - the palette constant array (8 entries) and the safe, unsafe and grid colour constants.
- One sub-module, sprite_hit: combinational hit test for a single slot, instantiated NUM_SPRITES times in a generate loop.

Test Plan:
- Reset release, disp_enbl=1, i_is_safe=1 at h=10, v=10 -> RGB = 0/3/0 exactly 2 clocks later; RGB = 0 during reset.
- Write slot 0 at x=100, y=100, en=1 mid-frame -> invisible this frame. After the commit pulse at v=600, h=0, pixel (100,100) and (115,115) show palette[0]; (116,100) shows background.
- Slots 0 and 1 both covering (200,200) -> palette[0] shown. Disable slot 0 and wait for a commit -> palette[1] shown.
- Sprite at x=790 -> pixels 790..799 coloured; no hit at h=0..5 on the same line (no wrap).
- i_is_safe=0 constantly, BLINK_FRAMES=2 -> unsafe red alternates F,F,4,4,F across successive frames.
- Write asserted in the commit cycle -> o_spr_ready=0 that cycle, accepted the next cycle, visible after the following commit. disp_enbl=0 -> RGB = 0 even over a sprite.
